// File: rtl/long_and_arb_pkg.sv
// Shared types and helpers for the long_and round-robin arbiter slice.
package long_and_arb_pkg;

  typedef enum logic {IDLE, BUSY} state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/long_and.sv
// AND-reduction of one LENGTH-bit operand vector.
module long_and #(
  parameter int LENGTH = 8
) (
  input  logic [LENGTH-1:0] a_i,
  output logic              y_o
);

  assign y_o = &a_i;

endmodule

// File: rtl/long_and_rr_arbiter.sv
// Round-robin sharing of a single long_and reducer among NREQ requesters,
// with a one-deep registered response carrying the requester id.
module long_and_rr_arbiter
  import long_and_arb_pkg::*;
#(
  parameter  int LENGTH = 8,
  parameter  int NREQ   = 4,
  localparam int ID_W   = id_width(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*LENGTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  output logic                   rsp_y,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready
);

  localparam int unsigned NREQ_U = NREQ;

  state_e            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_d;
  logic              rsp_y_q;
  logic [ID_W-1:0]   rsp_id_q;

  logic              can_accept;
  logic              accept;
  logic [ID_W-1:0]   grant_idx;
  logic [LENGTH-1:0] operand;
  logic              y;

  // First valid index scanning ptr, ptr+1, ... modulo NREQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                              input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      idx = (32'(ptr) + k) % NREQ_U;
      if (!found && valid[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign can_accept = (state_q == IDLE) | rsp_ready;
  assign grant_idx  = rr_pick(req_valid, ptr_q);
  // rst_n gates the grant so nothing is offered while reset is held.
  assign accept     = rst_n & can_accept & (|req_valid);

  always_comb begin
    req_ready = '0;
    operand   = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (grant_idx == ID_W'(i)) begin
        req_ready[i] = accept;
        operand      = req_data[i*LENGTH +: LENGTH];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (32'(grant_idx) == NREQ_U - 1) ptr_d = '0;
      else                              ptr_d = grant_idx + 1'b1;
    end
  end

  long_and #(.LENGTH(LENGTH)) u_long_and (
    .a_i (operand),
    .y_o (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      rsp_y_q  <= 1'b0;
      rsp_id_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (accept) begin
        state_q  <= BUSY;
        rsp_y_q  <= y;
        rsp_id_q <= grant_idx;
      end else if (state_q == BUSY && rsp_ready) begin
        state_q <= IDLE;
      end
    end
  end

  assign rsp_valid = (state_q == BUSY);
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;

endmodule
